// File: rtl/arbiter_puf_pkg.sv
// Shared FSM state encoding for the arbiter PUF with temporal majority voting.
package arbiter_puf_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE,
    SETTLE,
    RACE,
    ACCUM,
    DONE
  } state_e;

endpackage

// File: rtl/arbiter_delay_chain.sv
// Switch chain plus arbiter flop; the race bit is 1 when path0 wins. Real chain output crosses
// into core_clk through a 2-flop synchroniser. SIM_MODEL swaps in a parity-plus-noise model.
module arbiter_delay_chain #(
  parameter int N_STAGES  = 64,
  parameter int SIM_MODEL = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                launch,
  input  logic [N_STAGES-1:0] chal,
  input  logic                noise_i,
  output logic                race
);

  if (SIM_MODEL != 0) begin : g_model
    logic unused_sim;
    assign unused_sim = ^{clk, rst_n, launch};
    assign race = (^chal) ^ noise_i;
  end else begin : g_chain
    logic       path0, path1, swap_tmp;
    logic       arb_q;
    logic [1:0] sync_q;
    logic       unused_noise;

    assign unused_noise = noise_i;

    // Each set challenge bit crosses the two paths; stage cells need dont_touch and symmetric placement.
    always_comb begin
      path0    = launch;
      path1    = launch;
      swap_tmp = 1'b0;
      for (int i = 0; i < N_STAGES; i++) begin
        if (chal[i]) begin
          swap_tmp = path0;
          path0    = path1;
          path1    = swap_tmp;
        end
      end
    end

    always_ff @(posedge path1) begin
      arb_q <= path0;
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        sync_q <= 2'b00;
      end else begin
        sync_q <= {sync_q[0], arb_q};
      end
    end

    assign race = sync_q[1];
  end

endmodule

// File: rtl/arbiter_puf_tmv.sv
// Arbiter PUF evaluated N_EVAL times per request with majority vote; done pulses
// N_EVAL*(SETTLE_CYC+EVAL_CYC+1)+1 cycles after an accepted start, start ignored while mid-request.
module arbiter_puf_tmv
  import arbiter_puf_pkg::*;
#(
  parameter int  N_STAGES   = 64,
  parameter int  N_EVAL     = 7,
  parameter int  SETTLE_CYC = 4,
  parameter int  EVAL_CYC   = 4,
  parameter int  SIM_MODEL  = 0,
  localparam int CW         = $clog2(N_EVAL + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [N_STAGES-1:0] challenge,
  input  logic                noise_i,
  output logic                busy,
  output logic                done,
  output logic                response,
  output logic [CW-1:0]       ones_cnt,
  output logic                stable
);

  localparam int PH_MAX = (SETTLE_CYC > EVAL_CYC) ? SETTLE_CYC : EVAL_CYC;
  localparam int PW     = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

  state_e              state_q;
  logic [N_STAGES-1:0] chal_q;
  logic [PW-1:0]       phase_q;
  logic [CW-1:0]       eval_idx_q;
  logic [CW-1:0]       acc_q;
  logic [CW-1:0]       acc_d;
  logic [CW-1:0]       ones_cnt_q;
  logic                launch_q;
  logic                race;
  logic                race_q;
  logic                busy_q;
  logic                done_q;
  logic                response_q;
  logic                stable_q;

  assign acc_d = acc_q + CW'(race_q);

  arbiter_delay_chain #(
    .N_STAGES (N_STAGES),
    .SIM_MODEL(SIM_MODEL)
  ) u_chain (
    .clk    (clk),
    .rst_n  (rst_n),
    .launch (launch_q),
    .chal   (chal_q),
    .noise_i(noise_i),
    .race   (race)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      chal_q     <= '0;
      phase_q    <= '0;
      eval_idx_q <= '0;
      acc_q      <= '0;
      launch_q   <= 1'b0;
      race_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      response_q <= 1'b0;
      ones_cnt_q <= '0;
      stable_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            chal_q     <= challenge;
            eval_idx_q <= '0;
            acc_q      <= '0;
            phase_q    <= '0;
            busy_q     <= 1'b1;
            state_q    <= SETTLE;
          end
        end
        SETTLE: begin
          if (phase_q == PW'(SETTLE_CYC - 1)) begin
            phase_q  <= '0;
            launch_q <= 1'b1;
            state_q  <= RACE;
          end else begin
            phase_q <= phase_q + PW'(1);
          end
        end
        RACE: begin
          if (phase_q == PW'(EVAL_CYC - 1)) begin
            phase_q  <= '0;
            launch_q <= 1'b0;
            race_q   <= race;
            state_q  <= ACCUM;
          end else begin
            phase_q <= phase_q + PW'(1);
          end
        end
        ACCUM: begin
          acc_q <= acc_d;
          if (eval_idx_q == CW'(N_EVAL - 1)) begin
            state_q <= DONE;
          end else begin
            eval_idx_q <= eval_idx_q + CW'(1);
            state_q    <= SETTLE;
          end
        end
        DONE: begin
          done_q     <= 1'b1;
          ones_cnt_q <= acc_q;
          response_q <= (acc_q > CW'(N_EVAL / 2));
          stable_q   <= (acc_q == '0) || (acc_q == CW'(N_EVAL));
          // A start here chains straight into the next request, so busy never drops.
          if (start) begin
            chal_q     <= challenge;
            eval_idx_q <= '0;
            acc_q      <= '0;
            phase_q    <= '0;
            state_q    <= SETTLE;
          end else begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign response = response_q;
  assign ones_cnt = ones_cnt_q;
  assign stable   = stable_q;

endmodule

// File: tb/tb_arbiter_puf_tmv.sv
// Scoreboard bench: two model-mode instances (default sizing and minimal 1/1/1 sizing).
module tb_arbiter_puf_tmv;

  localparam int NE   = 7;
  localparam int SC   = 4;
  localparam int EC   = 4;
  localparam int P    = SC + EC + 1;
  localparam int L    = NE * P + 1;
  localparam int NE_B = 1;
  localparam int P_B  = 3;
  localparam int L_B  = NE_B * P_B + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start_a, noise_a, busy_a, done_a, resp_a, stab_a;
  logic [63:0] chal_a;
  logic [2:0]  ones_a;
  logic        start_b, noise_b, busy_b, done_b, resp_b, stab_b;
  logic [63:0] chal_b;
  logic [0:0]  ones_b;

  arbiter_puf_tmv #(.N_STAGES(64), .N_EVAL(NE), .SETTLE_CYC(SC), .EVAL_CYC(EC), .SIM_MODEL(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .challenge(chal_a), .noise_i(noise_a),
    .busy(busy_a), .done(done_a), .response(resp_a), .ones_cnt(ones_a), .stable(stab_a));

  arbiter_puf_tmv #(.N_STAGES(64), .N_EVAL(NE_B), .SETTLE_CYC(1), .EVAL_CYC(1), .SIM_MODEL(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .challenge(chal_b), .noise_i(noise_b),
    .busy(busy_b), .done(done_b), .response(resp_b), .ones_cnt(ones_b), .stable(stab_b));

  typedef struct {
    logic   resp;
    int     ones;
    logic   stab;
    longint at;
  } exp_t;

  exp_t   q_a[$];
  exp_t   q_b[$];
  int     errors = 0;
  int     checks = 0;
  longint cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Each race outcome is the challenge parity, inverted by that race's noise flip.
  function automatic exp_t model(input logic [63:0] chal, input logic [6:0] flips,
                                 input int n, input longint at);
    exp_t e;
    int   ones = 0;
    bit   par;
    par = ($countones(chal) % 2) == 1;
    for (int i = 0; i < n; i++) ones += (par != flips[i]) ? 1 : 0;
    e.ones = ones;
    e.resp = (2 * ones > n);
    e.stab = (ones == 0) || (ones == n);
    e.at   = at;
    return e;
  endfunction

  always @(negedge clk) begin : mon_a
    exp_t e;
    if (done_a === 1'b1) begin
      if (q_a.size() == 0) begin
        check("a_spurious_done", done_a, 0);
      end else begin
        e = q_a.pop_front();
        check("a_done_cycle", cyc, e.at);
        check("a_response", resp_a, e.resp);
        check("a_ones_cnt", ones_a, e.ones);
        check("a_stable", stab_a, e.stab);
      end
    end
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    if (done_b === 1'b1) begin
      if (q_b.size() == 0) begin
        check("b_spurious_done", done_b, 0);
      end else begin
        e = q_b.pop_front();
        check("b_done_cycle", cyc, e.at);
        check("b_response", resp_b, e.resp);
        check("b_ones_cnt", ones_b, e.ones);
        check("b_stable", stab_b, e.stab);
      end
    end
  end

  // Called #1 after an edge; returns #1 after the edge that enters the final (DONE) state.
  task automatic issue_a(input logic [63:0] chal, input logic [6:0] flips, input bit disturb);
    longint s;
    start_a = 1'b1;
    chal_a  = chal;
    s       = cyc + 1;
    q_a.push_back(model(chal, flips, NE, s + L));
    @(posedge clk); #1;
    start_a = 1'b0;
    for (int i = 0; i < NE; i++) begin
      noise_a = flips[i];
      check("a_busy_mid", busy_a, 1);
      if (disturb) begin
        start_a = 1'($urandom_range(0, 1));
        chal_a  = {$urandom, $urandom};
      end
      repeat (P) @(posedge clk);
      #1;
    end
    check("a_busy_pre_done", busy_a, 1);
    start_a = 1'b0;
    noise_a = 1'b0;
    chal_a  = {$urandom, $urandom};
  endtask

  task automatic wait_a();
    for (int k = 0; k < 2 * L && q_a.size() != 0; k++) @(negedge clk);
    if (q_a.size() != 0) begin
      check("a_done_timeout", q_a.size(), 0);
      q_a.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic issue_b(input logic [63:0] chal, input logic flip);
    longint s;
    start_b = 1'b1;
    chal_b  = chal;
    s       = cyc + 1;
    q_b.push_back(model(chal, {6'b0, flip}, NE_B, s + L_B));
    @(posedge clk); #1;
    start_b = 1'b0;
    noise_b = flip;
    check("b_busy_mid", busy_b, 1);
    repeat (P_B) @(posedge clk);
    #1;
    noise_b = 1'b0;
    for (int k = 0; k < 4 * L_B && q_b.size() != 0; k++) @(negedge clk);
    if (q_b.size() != 0) begin
      check("b_done_timeout", q_b.size(), 0);
      q_b.delete();
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    rst_n   = 1'b0;
    start_a = 1'b0; noise_a = 1'b0; chal_a = '0;
    start_b = 1'b0; noise_b = 1'b0; chal_b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_response", resp_a, 0);
    check("rst_ones_cnt", ones_a, 0);
    check("rst_stable", stab_a, 0);
    check("rst_b_busy", busy_b, 0);
    check("rst_b_ones_cnt", ones_b, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    issue_a(64'h1, 7'b0000000, 1'b0);
    wait_a();

    // Abort mid-request during the second race window.
    start_a = 1'b1;
    chal_a  = {$urandom, $urandom};
    @(posedge clk); #1;
    start_a = 1'b0;
    repeat (P + SC + 1) @(posedge clk);
    #1;
    check("abort_busy_before", busy_a, 1);
    check("hold_response", resp_a, 1);
    check("hold_ones_cnt", ones_a, 7);
    check("hold_stable", stab_a, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("abort_busy", busy_a, 0);
    check("abort_done", done_a, 0);
    check("abort_response", resp_a, 0);
    check("abort_ones_cnt", ones_a, 0);
    check("abort_stable", stab_a, 0);
    rst_n = 1'b1;
    repeat (2 * L) @(posedge clk);
    #1;
    check("abort_idle_busy", busy_a, 0);

    issue_a(64'h3, 7'b0010101, 1'b0);
    wait_a();
    issue_a(64'h3, 7'b1011010, 1'b0);
    wait_a();

    // Inputs toggled while busy, then back-to-back requests chained from DONE.
    issue_a({$urandom, $urandom}, 7'($urandom_range(0, 127)), 1'b1);
    issue_a({$urandom, $urandom}, 7'($urandom_range(0, 127)), 1'b1);
    wait_a();

    for (int n = 0; n < 6; n++) begin
      issue_a({$urandom, $urandom}, 7'($urandom_range(0, 127)), 1'($urandom_range(0, 1)));
      wait_a();
    end

    for (int n = 0; n < 6; n++) begin
      issue_b({$urandom, $urandom}, 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
